module_mux_ps: RTL

Parallel-to-serial channel multiplexer. It is the transmit-side counterpart of the DDC serial->parallel demux.
- Accepts independent per-channel sample strobes (e.g. I and Q from the CIC/FIR chain) and buffers each in a small per-channel FIFO.
- Emits one time-multiplexed stream: data word, valid pulse and 4-bit channel index. Index 1 = I, 2 = Q, ..., 0 = idle.
- Sits between the decimation filters and the serial link toward the demux/host.

---
 rtl/mux_pkg.sv | 25 ++
 rtl/mux_ps_chan_fifo.sv | 63 ++++++
 rtl/module_mux_ps.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the parallel-to-serial channel mux and its demux
// counterpart: channel tag encoding, default slot timing and FSM states.
package mux_pkg;

    localparam int CHIDX_WIDTH = 4;

    localparam logic [CHIDX_WIDTH-1:0] CHIDX_IDLE = 4'd0;
    localparam logic [CHIDX_WIDTH-1:0] CHIDX_I    = 4'd1;
    localparam logic [CHIDX_WIDTH-1:0] CHIDX_Q    = 4'd2;

    // Slot timing shared with the demux so both ends agree on framing.
    localparam int DEF_SLOT_CLK_NUM    = 4;
    localparam int DEF_VALID_HIGH_CLKS = 2;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SLOT = 1'b1
    } mux_state_t;

    // Channel k is tagged k+1 on the serial link; 0 is reserved for idle.
    function automatic logic [CHIDX_WIDTH-1:0] ch_to_idx(input logic [CHIDX_WIDTH-1:0] ch);
        return ch + 4'd1;
    endfunction

endpackage

// File: rtl/mux_ps_chan_fifo.sv
// Per-channel first-word-fall-through FIFO. dout always shows the oldest
// entry while not empty; rd pops it. A write to a full FIFO is accepted
// only when a pop happens on the same edge.
module mux_ps_chan_fifo #(
    parameter int DATA_WIDTH = 24,
    parameter int FIFO_AW    = 2
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  wr,
    input  logic                  rd,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [FIFO_AW:0]      count,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = 1 << FIFO_AW;

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [FIFO_AW-1:0]    wr_ptr_r;
    logic [FIFO_AW-1:0]    rd_ptr_r;
    logic [FIFO_AW:0]      count_r;
    logic                  do_rd_s;
    logic                  do_wr_s;

    assign empty   = (count_r == {(FIFO_AW+1){1'b0}});
    assign full    = (count_r == (FIFO_AW+1)'(DEPTH));
    assign count   = count_r;
    assign dout    = mem_r[rd_ptr_r];
    assign do_rd_s = rd & ~empty;
    assign do_wr_s = wr & (~full | do_rd_s);

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge CLK) begin
        if (do_wr_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr_r <= {FIFO_AW{1'b0}};
            rd_ptr_r <= {FIFO_AW{1'b0}};
            count_r  <= {(FIFO_AW+1){1'b0}};
        end else begin
            if (do_wr_s) begin
                wr_ptr_r <= wr_ptr_r + {{(FIFO_AW-1){1'b0}}, 1'b1};
            end
            if (do_rd_s) begin
                rd_ptr_r <= rd_ptr_r + {{(FIFO_AW-1){1'b0}}, 1'b1};
            end
            case ({do_wr_s, do_rd_s})
                2'b10:   count_r <= count_r + {{FIFO_AW{1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{FIFO_AW{1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/module_mux_ps.sv
// Parallel-to-serial channel multiplexer. Buffers per-channel sample strobes
// in small FIFOs and emits them round-robin as fixed-length slots carrying
// data, a valid pulse at the slot start and a channel tag (0 = idle).
module module_mux_ps
    import mux_pkg::*;
#(
    parameter int DATA_WIDTH      = 24,
    parameter int NUM_CH          = 2,
    parameter int FIFO_AW         = 2,
    parameter int SLOT_CLK_NUM    = DEF_SLOT_CLK_NUM,
    parameter int VALID_HIGH_CLKS = DEF_VALID_HIGH_CLKS
) (
    input  logic                         CLK,
    input  logic                         nRST,
    input  logic [NUM_CH*DATA_WIDTH-1:0] Data_In,
    input  logic [NUM_CH-1:0]            Data_In_Valid,
    input  logic                         Ovf_Clr,
    output logic [DATA_WIDTH-1:0]        Data_Out,
    output logic                         Data_Out_Valid,
    output logic [CHIDX_WIDTH-1:0]       Data_Out_ChIdx,
    output logic [NUM_CH-1:0]            Ovf
);

    localparam int CH_W  = CHIDX_WIDTH;
    localparam int CNT_W = $clog2(SLOT_CLK_NUM) + 1;

    mux_state_t            state_r;
    mux_state_t            state_nxt_s;
    logic [CNT_W-1:0]      cnt_r;
    logic [CNT_W-1:0]      cnt_nxt_s;
    logic [CH_W-1:0]       rr_r;
    logic [CH_W-1:0]       rr_nxt_s;
    logic [DATA_WIDTH-1:0] data_r;
    logic [DATA_WIDTH-1:0] data_nxt_s;
    logic                  valid_r;
    logic                  valid_nxt_s;
    logic [CH_W-1:0]       chidx_r;
    logic [CH_W-1:0]       chidx_nxt_s;
    logic [NUM_CH-1:0]     ovf_r;
    logic [NUM_CH-1:0]     ovf_nxt_s;

    logic [NUM_CH-1:0]     ne_s;
    logic [NUM_CH-1:0]     pop_s;
    logic [NUM_CH-1:0]     wr_s;
    logic [NUM_CH-1:0]     drop_s;
    logic [NUM_CH-1:0]     full_s;
    logic [NUM_CH-1:0]     empty_s;
    logic [DATA_WIDTH-1:0] fifo_dout_s [NUM_CH];
    logic [FIFO_AW:0]      fifo_cnt_s  [NUM_CH];

    logic                  any_ne_s;
    logic [CH_W-1:0]       win_s;
    logic [CH_W:0]         cand_s;
    logic [DATA_WIDTH-1:0] win_data_s;
    logic                  slot_end_s;
    logic                  start_s;

    // Per-channel FIFOs; a full FIFO still accepts a write when popped on the same edge.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign ne_s[g]   = ~empty_s[g];
        assign wr_s[g]   = Data_In_Valid[g] & (~full_s[g] | pop_s[g]);
        assign drop_s[g] = Data_In_Valid[g] & full_s[g] & ~pop_s[g];

        mux_ps_chan_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .FIFO_AW    (FIFO_AW)
        ) u_fifo (
            .CLK   (CLK),
            .nRST  (nRST),
            .wr    (wr_s[g]),
            .rd    (pop_s[g]),
            .din   (Data_In[g*DATA_WIDTH +: DATA_WIDTH]),
            .dout  (fifo_dout_s[g]),
            .count (fifo_cnt_s[g]),
            .full  (full_s[g]),
            .empty (empty_s[g])
        );
    end

    assign slot_end_s = (state_r == ST_SLOT) && (cnt_r == CNT_W'(SLOT_CLK_NUM - 1));
    assign start_s    = any_ne_s && ((state_r == ST_IDLE) || slot_end_s);
    assign ovf_nxt_s  = (ovf_r & ~{NUM_CH{Ovf_Clr}}) | drop_s;

    // Round-robin search: first non-empty channel at or after rr_r, wrapping.
    always_comb begin
        any_ne_s = 1'b0;
        win_s    = {CH_W{1'b0}};
        cand_s   = {(CH_W+1){1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            cand_s = {1'b0, rr_r} + (CH_W+1)'(i);
            if (cand_s >= (CH_W+1)'(NUM_CH)) begin
                cand_s = cand_s - (CH_W+1)'(NUM_CH);
            end else begin
                cand_s = cand_s;
            end
            for (int j = 0; j < NUM_CH; j++) begin
                if (!any_ne_s && ne_s[j] && (cand_s == (CH_W+1)'(j))) begin
                    any_ne_s = 1'b1;
                    win_s    = CH_W'(j);
                end else begin
                    any_ne_s = any_ne_s;
                end
            end
        end
    end

    // Head-of-FIFO word of the arbitration winner.
    always_comb begin
        win_data_s = {DATA_WIDTH{1'b0}};
        for (int j = 0; j < NUM_CH; j++) begin
            if (win_s == CH_W'(j)) begin
                win_data_s = fifo_dout_s[j];
            end else begin
                win_data_s = win_data_s;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state: leave IDLE on any pending word, leave SLOT only at its end with nothing pending.
    always_comb begin
        case (state_r)
            ST_IDLE: begin
                if (any_ne_s) begin
                    state_nxt_s = ST_SLOT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SLOT: begin
                if (slot_end_s && !any_ne_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_SLOT;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM outputs: pop and load at slot start, count through the slot, drop to idle tag otherwise.
    always_comb begin
        pop_s       = {NUM_CH{1'b0}};
        cnt_nxt_s   = {CNT_W{1'b0}};
        data_nxt_s  = data_r;
        valid_nxt_s = 1'b0;
        chidx_nxt_s = CHIDX_IDLE;
        rr_nxt_s    = rr_r;
        if (start_s) begin
            // Defensive: never pop a FIFO whose occupancy reads zero.
            for (int j = 0; j < NUM_CH; j++) begin
                pop_s[j] = (win_s == CH_W'(j)) && (fifo_cnt_s[j] != {(FIFO_AW+1){1'b0}});
            end
            data_nxt_s  = win_data_s;
            chidx_nxt_s = ch_to_idx(win_s);
            valid_nxt_s = 1'b1;
            cnt_nxt_s   = {CNT_W{1'b0}};
            if (win_s == CH_W'(NUM_CH - 1)) begin
                rr_nxt_s = {CH_W{1'b0}};
            end else begin
                rr_nxt_s = win_s + {{(CH_W-1){1'b0}}, 1'b1};
            end
        end else if ((state_r == ST_SLOT) && !slot_end_s) begin
            cnt_nxt_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            valid_nxt_s = ((cnt_r + {{(CNT_W-1){1'b0}}, 1'b1}) < CNT_W'(VALID_HIGH_CLKS));
            chidx_nxt_s = chidx_r;
        end else begin
            cnt_nxt_s   = {CNT_W{1'b0}};
            valid_nxt_s = 1'b0;
            chidx_nxt_s = CHIDX_IDLE;
        end
    end

    // Registered datapath and outputs; async reset clears everything mid-slot.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt_r   <= {CNT_W{1'b0}};
            rr_r    <= {CH_W{1'b0}};
            data_r  <= {DATA_WIDTH{1'b0}};
            valid_r <= 1'b0;
            chidx_r <= CHIDX_IDLE;
            ovf_r   <= {NUM_CH{1'b0}};
        end else begin
            cnt_r   <= cnt_nxt_s;
            rr_r    <= rr_nxt_s;
            data_r  <= data_nxt_s;
            valid_r <= valid_nxt_s;
            chidx_r <= chidx_nxt_s;
            ovf_r   <= ovf_nxt_s;
        end
    end

    assign Data_Out       = data_r;
    assign Data_Out_Valid = valid_r;
    assign Data_Out_ChIdx = chidx_r;
    assign Ovf            = ovf_r;

endmodule
